tohost_capture: RTL and testbench

Passive snoop stage directly upstream of the testbench pass/fail and coverage logic. It watches the memory write channel into the test SRAM, collects byte-masked writes to the HTIF `tohost` doubleword, and publishes a registered 64-bit `tohost` value. It also produces one-cycle pass/fail pulses. It replaces hierarchical peeking at memory: the round checker and `coverage_monitor` consume `tohost`/`tohost_valid` from this block.

---
 rtl/tohost_capture.sv | 190 +++++++++++++++++++
 tb/tb_tohost_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tohost_capture.sv
// Snoops the test-SRAM write channel and captures byte-masked writes to the HTIF tohost doubleword.
// Publishes a registered tohost value with one-cycle pass/fail pulses and a sticky overrun flag.
module tohost_capture #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR     = 32'h8000_1000,
    parameter int                    PARTIAL_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [63:0]           wr_data,
    input  logic [7:0]            wr_mask,
    input  logic                  clear,
    output logic [63:0]           tohost,
    output logic                  tohost_valid,
    output logic                  pass,
    output logic                  fail,
    output logic [62:0]           fail_code,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(PARTIAL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PARTIAL_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        PARTIAL,
        COMMIT,
        HOLD
    } state_t;

    state_t         state, state_n;
    logic [63:0]    shadow, shadow_n;
    logic [7:0]     acc_mask, acc_mask_n;
    logic [CNT_W-1:0] count, count_n;
    logic [63:0]    tohost_q, tohost_n;
    logic           valid_q, valid_n;
    logic           pass_q, pass_n;
    logic           fail_q, fail_n;
    logic           overrun_q, overrun_n;

    logic           match;
    logic [63:0]    byte_en;
    logic [63:0]    fresh;
    logic [63:0]    merged;
    logic [7:0]     acc_or;
    logic           do_commit;
    logic           go_idle;
    logic [63:0]    commit_value;

    // Low address bits select nothing; lanes come from the mask.
    logic unused_addr_bits;
    assign unused_addr_bits = ^wr_addr[2:0];

    assign match = wr_valid && wr_ready
                   && (wr_addr[ADDR_WIDTH-1:3] == TOHOST_ADDR[ADDR_WIDTH-1:3])
                   && (wr_mask != 8'h00);

    always_comb begin
        byte_en = '0;
        for (int i = 0; i < 8; i++) begin
            byte_en[i*8 +: 8] = {8{wr_mask[i]}};
        end
    end

    assign fresh  = wr_data & byte_en;
    assign merged = (shadow & ~byte_en) | fresh;
    assign acc_or = acc_mask | wr_mask;

    always_comb begin
        state_n      = state;
        shadow_n     = shadow;
        acc_mask_n   = acc_mask;
        count_n      = count;
        tohost_n     = tohost_q;
        valid_n      = valid_q;
        pass_n       = 1'b0;
        fail_n       = 1'b0;
        overrun_n    = overrun_q;
        do_commit    = 1'b0;
        go_idle      = 1'b0;
        commit_value = '0;

        if (clear) begin
            state_n    = IDLE;
            shadow_n   = '0;
            acc_mask_n = '0;
            count_n    = '0;
            tohost_n   = '0;
            valid_n    = 1'b0;
            overrun_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match) begin
                        shadow_n   = fresh;
                        acc_mask_n = wr_mask;
                        if (wr_mask == 8'hFF) begin
                            commit_value = fresh;
                            // A full write of zero is software clearing tohost, not an event.
                            if (fresh != 64'd0) do_commit = 1'b1;
                            else                go_idle   = 1'b1;
                        end else begin
                            state_n = PARTIAL;
                            count_n = CNT_LOAD;
                        end
                    end
                end
                PARTIAL: begin
                    if (match) begin
                        shadow_n   = merged;
                        acc_mask_n = acc_or;
                        count_n    = CNT_LOAD;
                        if (acc_or == 8'hFF) begin
                            commit_value = merged;
                            if (merged != 64'd0) do_commit = 1'b1;
                            else                 go_idle   = 1'b1;
                        end
                    end else begin
                        count_n = count - CNT_W'(1);
                        // Timed out: commit with unwritten bytes as zero (RV32 low-word store).
                        if (count <= CNT_W'(1)) begin
                            commit_value = shadow;
                            if (shadow != 64'd0) do_commit = 1'b1;
                            else                 go_idle   = 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_n = HOLD;
                    if (match) overrun_n = 1'b1;
                end
                HOLD: begin
                    if (match) overrun_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (do_commit) begin
                state_n  = COMMIT;
                tohost_n = commit_value;
                valid_n  = 1'b1;
                pass_n   = (commit_value == 64'd1);
                fail_n   = commit_value[0] && (commit_value != 64'd1);
            end else if (go_idle) begin
                state_n    = IDLE;
                shadow_n   = '0;
                acc_mask_n = '0;
                count_n    = '0;
            end
        end
    end

    // Outputs are registered alongside the state so nothing flows combinationally from wr_*.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            acc_mask  <= '0;
            count     <= '0;
            tohost_q  <= '0;
            valid_q   <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            acc_mask  <= acc_mask_n;
            count     <= count_n;
            tohost_q  <= tohost_n;
            valid_q   <= valid_n;
            pass_q    <= pass_n;
            fail_q    <= fail_n;
            overrun_q <= overrun_n;
        end
    end

    assign tohost       = tohost_q;
    assign tohost_valid = valid_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign fail_code    = tohost_q[63:1];
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tohost_capture.sv
// Directed bench for tohost_capture: hand-computed expectations for commit, timeout, overrun,
// clear and asynchronous reset behaviour.
module tb_tohost_capture;

    localparam int          ADDR_WIDTH      = 32;
    localparam logic [31:0] TOHOST_ADDR     = 32'h8000_1000;
    localparam int          PARTIAL_TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic        clear = 1'b0;
    logic [63:0] tohost;
    logic        tohost_valid;
    logic        pass;
    logic        fail;
    logic [62:0] fail_code;
    logic        overrun;

    int vector_count = 0;
    int miscompare_count = 0;

    tohost_capture #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .TOHOST_ADDR     (TOHOST_ADDR),
        .PARTIAL_TIMEOUT (PARTIAL_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_mask      (wr_mask),
        .clear        (clear),
        .tohost       (tohost),
        .tohost_valid (tohost_valid),
        .pass         (pass),
        .fail         (fail),
        .fail_code    (fail_code),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] exp_tohost, input logic exp_valid,
                             input logic exp_pass, input logic exp_fail, input logic exp_overrun);
        logic [63:0] exp_code;
        exp_code = {1'b0, exp_tohost[63:1]};
        check_output({tag, ".tohost"},    tohost,                exp_tohost);
        check_output({tag, ".valid"},     64'(tohost_valid),     64'(exp_valid));
        check_output({tag, ".pass"},      64'(pass),             64'(exp_pass));
        check_output({tag, ".fail"},      64'(fail),             64'(exp_fail));
        check_output({tag, ".fail_code"}, {1'b0, fail_code},     exp_code);
        check_output({tag, ".overrun"},   64'(overrun),          64'(exp_overrun));
    endtask

    // Presents one cycle of inputs, lets the edge take them, then returns 1ns after it.
    task automatic apply_stimulus(input logic valid, input logic ready, input logic [31:0] addr,
                                  input logic [63:0] data, input logic [7:0] mask, input logic clr);
        wr_valid = valid;
        wr_ready = ready;
        wr_addr  = addr;
        wr_data  = data;
        wr_mask  = mask;
        clear    = clr;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        wr_ready = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_mask  = '0;
        clear    = 1'b0;
    endtask

    task automatic write_tohost(input logic [63:0] data, input logic [7:0] mask);
        apply_stimulus(1'b1, 1'b1, TOHOST_ADDR, data, mask, 1'b0);
    endtask

    task automatic do_clear();
        apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 check_all("reset_async", 64'd0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        check_all("reset_held", 64'd0, 0, 0, 0, 0);
        reset = 1'b0;
        idle(1);

        // Full-width write of 1
        write_tohost(64'd1, 8'hFF);
        check_all("full_pass", 64'd1, 1, 1, 0, 0);
        idle(1);
        check_all("full_pass_after", 64'd1, 1, 0, 0, 0);
        do_clear();
        check_all("full_pass_clear", 64'd0, 0, 0, 0, 0);

        // Fail code and syscall pointer
        write_tohost(64'd7, 8'hFF);
        check_all("fail7", 64'd7, 1, 0, 1, 0);
        check_output("fail7.code3", {1'b0, fail_code}, 64'd3);
        idle(1);
        check_all("fail7_after", 64'd7, 1, 0, 0, 0);
        do_clear();
        write_tohost(64'h80, 8'hFF);
        check_all("syscall", 64'h80, 1, 0, 0, 0);
        do_clear();

        // Split write, second half two cycles later
        write_tohost(64'hAAAA_AAAA_0000_0003, 8'h0F);
        check_all("split_first", 64'd0, 0, 0, 0, 0);
        idle(1);
        write_tohost(64'h0000_0001_BBBB_BBBB, 8'hF0);
        check_all("split_done", 64'h0000_0001_0000_0003, 1, 0, 1, 0);
        do_clear();

        // Back-to-back partials, later write wins on byte 0
        write_tohost(64'h0000_0000_0000_00FF, 8'h0F);
        write_tohost(64'h0000_0000_0000_0002, 8'h01);
        check_all("b2b_mid", 64'd0, 0, 0, 0, 0);
        write_tohost(64'h0000_0000_0000_0000, 8'hF0);
        check_all("b2b_done", 64'd2, 1, 0, 0, 0);
        do_clear();

        // Lone low-word write commits after the timeout
        write_tohost(64'd3, 8'h0F);
        idle(PARTIAL_TIMEOUT - 1);
        check_all("timeout_early", 64'd0, 0, 0, 0, 0);
        idle(1);
        check_all("timeout_commit", 64'd3, 1, 0, 1, 0);
        do_clear();

        // Writes that must not change anything
        write_tohost(64'd0, 8'hFF);
        check_all("zero_write", 64'd0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b1, TOHOST_ADDR + 32'd8, 64'd1, 8'hFF, 1'b0);
        check_all("other_addr", 64'd0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, TOHOST_ADDR, 64'd1, 8'hFF, 1'b0);
        check_all("not_ready", 64'd0, 0, 0, 0, 0);
        write_tohost(64'd1, 8'h00);
        idle(PARTIAL_TIMEOUT + 2);
        check_all("ignored_quiet", 64'd0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b1, TOHOST_ADDR + 32'd4, 64'd1, 8'hFF, 1'b0);
        check_all("low_bits_ignored", 64'd1, 1, 1, 0, 0);
        do_clear();

        // Overrun in HOLD, then clear beating a same-cycle write
        write_tohost(64'd1, 8'hFF);
        check_all("ovr_commit", 64'd1, 1, 1, 0, 0);
        idle(1);
        write_tohost(64'd5, 8'hFF);
        check_all("ovr_set", 64'd1, 1, 0, 0, 1);
        apply_stimulus(1'b1, 1'b1, TOHOST_ADDR, 64'd1, 8'hFF, 1'b1);
        check_all("clear_wins", 64'd0, 0, 0, 0, 0);
        idle(1);
        check_all("clear_no_commit", 64'd0, 0, 0, 0, 0);
        write_tohost(64'd1, 8'hFF);
        check_all("rearmed", 64'd1, 1, 1, 0, 0);
        idle(1);

        // Asynchronous reset while holding a committed value
        #2 reset = 1'b1;
        #1 check_all("async_hold", 64'd0, 0, 0, 0, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Asynchronous reset between split halves
        write_tohost(64'd3, 8'h0F);
        idle(1);
        #2 reset = 1'b1;
        #1 check_all("async_partial", 64'd0, 0, 0, 0, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        write_tohost(64'h0000_0001_0000_0000, 8'hF0);
        idle(PARTIAL_TIMEOUT - 1);
        check_all("hi_half_early", 64'd0, 0, 0, 0, 0);
        idle(1);
        check_all("hi_half_commit", 64'h0000_0001_0000_0000, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
